// File: rtl/mul_iter_pkg.sv
// Shared definitions for the iterative shift-and-add multiplier: FSM state
// encodings and the step-counter width rule.
package mul_iter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  localparam int MUL_ITER_NBITS_DEF = 32;
  localparam int MUL_ITER_CNT_W     = $clog2(MUL_ITER_NBITS_DEF) + 1;

  // One extra bit so the counter can hold NBITS itself without wrapping.
  function automatic int mul_iter_cnt_w(input int nbits);
    return $clog2(nbits) + 1;
  endfunction

endpackage

// File: rtl/mul_iter_dpath.sv
// Datapath of the iterative multiplier: operand/result registers, adder and
// shifters. Exports b_zero only when MUL_ITER_SEQ_EARLY_EXIT_EN is defined.
module mul_iter_dpath
  import mul_iter_pkg::*;
#(
  parameter int NBITS = MUL_ITER_NBITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             add_en,
  input  logic             shift_en,
  input  logic [NBITS-1:0] msg_a,
  input  logic [NBITS-1:0] msg_b,
  output logic [NBITS-1:0] result,
`ifdef MUL_ITER_SEQ_EARLY_EXIT_EN
  output logic             b_zero,
`endif
  output logic             b_lsb
);

  logic [NBITS-1:0] a_q;
  logic [NBITS-1:0] b_q;
  logic [NBITS-1:0] res_q;

  // Plain modulo-2^NBITS add: the low product bits are the same for signed
  // and unsigned operands, so no sign handling is needed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else if (load) begin
      a_q   <= msg_a;
      b_q   <= msg_b;
      res_q <= '0;
    end else begin
      if (add_en)
        res_q <= res_q + a_q;
      if (shift_en) begin
        a_q <= a_q << 1;
        b_q <= b_q >> 1;
      end
    end
  end

  assign result = res_q;
  assign b_lsb  = b_q[0];
`ifdef MUL_ITER_SEQ_EARLY_EXIT_EN
  assign b_zero = (b_q == '0);
`endif

endmodule

// File: rtl/mul_iter_seq.sv
// Iterative shift-and-add multiplier (low NBITS of product) with val/rdy
// streams. Define MUL_ITER_SEQ_EARLY_EXIT_EN to stop once the multiplier is 0.
module mul_iter_seq
  import mul_iter_pkg::*;
#(
  parameter int NBITS = MUL_ITER_NBITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             istream_val,
  output logic             istream_rdy,
  input  logic [NBITS-1:0] istream_msg_a,
  input  logic [NBITS-1:0] istream_msg_b,
  output logic             ostream_val,
  input  logic             ostream_rdy,
  output logic [NBITS-1:0] ostream_msg
);

  localparam int              CW       = mul_iter_cnt_w(NBITS);
  localparam logic [CW-1:0]   CNT_LAST = CW'(NBITS - 1);

  mul_state_e    state, state_nxt;
  logic [CW-1:0] cnt;
  logic          load, add_en, shift_en;
  logic          b_lsb;
`ifdef MUL_ITER_SEQ_EARLY_EXIT_EN
  logic          b_zero;
`endif

  mul_iter_dpath #(.NBITS(NBITS)) u_dpath (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .add_en   (add_en),
    .shift_en (shift_en),
    .msg_a    (istream_msg_a),
    .msg_b    (istream_msg_b),
    .result   (ostream_msg),
`ifdef MUL_ITER_SEQ_EARLY_EXIT_EN
    .b_zero   (b_zero),
`endif
    .b_lsb    (b_lsb)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Counter advances only on real CALC steps and restarts on every load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (load)
      cnt <= '0;
    else if (shift_en)
      cnt <= cnt + CW'(1);
  end

  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    add_en      = 1'b0;
    shift_en    = 1'b0;
    istream_rdy = 1'b0;
    ostream_val = 1'b0;
    case (state)
      ST_IDLE: begin
        // Held low while reset is asserted, even though state is IDLE.
        istream_rdy = rst;
        if (istream_val && rst) begin
          load      = 1'b1;
          state_nxt = ST_CALC;
        end
      end
      ST_CALC: begin
`ifdef MUL_ITER_SEQ_EARLY_EXIT_EN
        if (b_zero) begin
          state_nxt = ST_DONE;
        end else begin
          add_en   = b_lsb;
          shift_en = 1'b1;
          if (cnt == CNT_LAST)
            state_nxt = ST_DONE;
        end
`else
        add_en   = b_lsb;
        shift_en = 1'b1;
        if (cnt == CNT_LAST)
          state_nxt = ST_DONE;
`endif
      end
      ST_DONE: begin
        ostream_val = 1'b1;
        if (ostream_rdy)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mul_iter_seq.sv
// Self-checking bench for mul_iter_seq: cycle-level reference model plus
// directed vectors with hand-computed products and latencies.
module tb_mul_iter_seq;

  localparam int NBITS = 32;

  logic             clk;
  logic             rst;
  logic             istream_val;
  logic             istream_rdy;
  logic [NBITS-1:0] istream_msg_a;
  logic [NBITS-1:0] istream_msg_b;
  logic             ostream_val;
  logic             ostream_rdy;
  logic [NBITS-1:0] ostream_msg;

  int total = 0;
  int bad   = 0;

  mul_iter_seq #(.NBITS(NBITS)) dut (
    .clk           (clk),
    .rst           (rst),
    .istream_val   (istream_val),
    .istream_rdy   (istream_rdy),
    .istream_msg_a (istream_msg_a),
    .istream_msg_b (istream_msg_b),
    .ostream_val   (ostream_val),
    .ostream_rdy   (ostream_rdy),
    .ostream_msg   (ostream_msg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected CALC-cycle count for a given multiplier value.
  function automatic int exp_lat(input logic [31:0] b);
    int m;
    m = -1;
    for (int i = 0; i < NBITS; i++)
      if (b[i]) m = i;
`ifdef MUL_ITER_SEQ_EARLY_EXIT_EN
    if (m < 0) return 1;
    return (m + 2 > NBITS) ? NBITS : m + 2;
`else
    return (m < -1) ? 0 : NBITS;
`endif
  endfunction

  // Reference model: one operation in flight, done after exp_lat edges.
  int          cyc = 0;
  bit          busy = 1'b0;
  int          done_at = 0;
  logic [31:0] prod = '0;

  always @(posedge clk) begin
    int prev;
    prev = cyc;
    cyc  = cyc + 1;
    if (rst !== 1'b1) begin
      busy = 1'b0;
    end else if (!busy) begin
      if (istream_val) begin
        busy    = 1'b1;
        done_at = cyc + exp_lat(istream_msg_b);
        prod    = istream_msg_a * istream_msg_b;
      end
    end else if (prev >= done_at && ostream_rdy) begin
      busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("rst_val", {31'b0, ostream_val}, 32'd0);
      chk("rst_rdy", {31'b0, istream_rdy}, 32'd0);
      chk("rst_msg", ostream_msg, 32'd0);
    end else if (rst === 1'b1) begin
      chk("mdl_val", {31'b0, ostream_val}, {31'b0, busy && cyc >= done_at});
      chk("mdl_rdy", {31'b0, istream_rdy}, {31'b0, !busy});
      if (busy && cyc >= done_at)
        chk("mdl_msg", ostream_msg, prod);
    end
  end

  task automatic wait_val(input logic lvl, input string name);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ostream_val === lvl) return;
    end
    chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Issue one request from IDLE with ostream_rdy=1; check product and latency.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_p, input int exp_n, input string name);
    int n;
    @(posedge clk); #1;
    istream_msg_a = a;
    istream_msg_b = b;
    istream_val   = 1'b1;
    @(posedge clk); #1;
    istream_val = 1'b0;
    n = 0;
    while (ostream_val !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_lat"}, n, exp_n);
    chk({name, "_msg"}, ostream_msg, exp_p);
    @(posedge clk); #1;
  endtask

`ifdef MUL_ITER_SEQ_EARLY_EXIT_EN
  localparam int L_3_4 = 4, L_M3_7 = 4, L_FF = 32, L_2_5 = 4;
`else
  localparam int L_3_4 = 32, L_M3_7 = 32, L_FF = 32, L_2_5 = 32;
`endif

  initial begin
    rst           = 1'b0;
    istream_val   = 1'b0;
    istream_msg_a = '0;
    istream_msg_b = '0;
    ostream_rdy   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdy", {31'b0, istream_rdy}, 32'd0);
    chk("reset_val", {31'b0, ostream_val}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rdy_after_reset", {31'b0, istream_rdy}, 32'd1);

    run_op(32'd3,        32'd4,        32'h0000000C, L_3_4,  "mul_3_4");
    run_op(32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, L_M3_7, "mul_m3_7");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, L_FF,   "mul_ff_ff");

    // Output back-pressure: result held for 5 cycles, no input acceptance.
    @(posedge clk); #1;
    istream_msg_a = 32'd6;
    istream_msg_b = 32'd7;
    istream_val   = 1'b1;
    ostream_rdy   = 1'b0;
    @(posedge clk); #1;
    istream_msg_a = 32'd100;
    wait_val(1'b1, "stall");
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_val", {31'b0, ostream_val}, 32'd1);
      chk("stall_msg", ostream_msg, 32'h0000002A);
      chk("stall_irdy", {31'b0, istream_rdy}, 32'd0);
    end
    istream_val = 1'b0;
    ostream_rdy = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_val", {31'b0, ostream_val}, 32'd0);
    chk("stall_release_irdy", {31'b0, istream_rdy}, 32'd1);

    // Reset 10 cycles into CALC abandons the operation.
    @(posedge clk); #1;
    istream_msg_a = 32'd123;
    istream_msg_b = 32'hFFFF0000;
    istream_val   = 1'b1;
    @(posedge clk); #1;
    istream_val = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_val", {31'b0, ostream_val}, 32'd0);
    chk("abort_msg", ostream_msg, 32'd0);
    chk("abort_irdy", {31'b0, istream_rdy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rdy_after", {31'b0, istream_rdy}, 32'd1);
    run_op(32'd2, 32'd5, 32'h0000000A, L_2_5, "mul_2_5");

`ifdef MUL_ITER_SEQ_EARLY_EXIT_EN
    run_op(32'd7, 32'd0,        32'h00000000, 1,  "ee_b0");
    run_op(32'd9, 32'd5,        32'h0000002D, 4,  "ee_9_5");
    run_op(32'd1, 32'h80000000, 32'h80000000, 32, "ee_msb");
`endif

    // Back-to-back with istream_val held high.
    @(posedge clk); #1;
    istream_msg_a = 32'd11;
    istream_msg_b = 32'd13;
    istream_val   = 1'b1;
    @(posedge clk); #1;
    istream_msg_a = 32'd17;
    istream_msg_b = 32'd19;
    wait_val(1'b1, "b2b_first");
    chk("b2b_first_msg", ostream_msg, 32'h0000008F);
    chk("b2b_first_irdy", {31'b0, istream_rdy}, 32'd0);
    wait_val(1'b0, "b2b_gap");
    wait_val(1'b1, "b2b_second");
    istream_val = 1'b0;
    chk("b2b_second_msg", ostream_msg, 32'h00000143);
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_iter_seq.md
MUL_ITER_SEQ -- requirements
Module: mul_iter_seq

Interface
REQ-001 SHALL have parameter NBITS, default 32: operand and result width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port istream_val  input  1  request valid.
REQ-005 SHALL have port istream_rdy  output  1  unit ready to accept a request.
REQ-006 SHALL have port istream_msg_a  input  NBITS  multiplicand.
REQ-007 SHALL have port istream_msg_b  input  NBITS  multiplier.
REQ-008 SHALL have port ostream_val  output  1  result valid.
REQ-009 SHALL have port ostream_rdy  input  1  consumer ready.
REQ-010 SHALL have port ostream_msg  output  NBITS  product, low NBITS bits.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-012 SHALL drive istream_rdy = 1 only in IDLE and ostream_val = 1 only in DONE.
REQ-013 SHALL transfer on a stream only when val and rdy are both 1 at a rising edge.
REQ-014 SHALL, on an IDLE input transfer, latch a and b, clear the result and the step counter, and enter CALC.
REQ-015 SHALL, in each CALC cycle, add a to the result if b[0] = 1, then shift a left by 1, shift b right by 1, and increment the counter.
REQ-016 SHALL, without the early-exit feature, leave CALC after exactly NBITS cycles, so ostream_val rises NBITS cycles after the accepting edge.
REQ-017 SHALL use modulo-2^NBITS arithmetic, discard carries, and give identical low bits for signed and unsigned operands (RISC-V mul semantics).
REQ-018 SHALL hold ostream_msg and ostream_val stable in DONE while ostream_rdy = 0.
REQ-019 SHALL return from DONE to IDLE on an output transfer, with no same-cycle input acceptance; the minimum initiation interval is therefore NBITS+2 cycles.
REQ-020 SHALL ignore istream_val and istream_msg_* outside IDLE.
REQ-021 SHALL clear the counter to 0 on each acceptance, so it never wraps within an operation.

Reset
REQ-022 SHALL, while rst = 0, asynchronously force state IDLE, set result, a, b and counter to 0, and hold ostream_val = 0 and ostream_msg = 0.
REQ-023 SHALL hold istream_rdy = 0 while rst = 0 and assert it in the first cycle after rst deasserts.
REQ-024 SHALL abandon an in-flight CALC or DONE operation on reset and never emit its result.

Configuration
REQ-025 SHALL, when MUL_ITER_SEQ_EARLY_EXIT_EN is defined, go from CALC to DONE at the edge that ends any CALC cycle that began with b = 0, with no add in that cycle.
REQ-026 SHALL, with the macro defined, spend b == 0 ? 1 : min(msb_index(b)+2, NBITS) CALC cycles, with results bit-identical to the undefined case.
REQ-027 SHALL, when the macro is undefined, contain no early-exit logic, so latency is fixed at NBITS.

Structure
REQ-028 SHALL take the FSM state enum typedef, the state encodings and the counter width constant $clog2(NBITS)+1 from shared package mul_iter_pkg.
REQ-029 SHALL split into control (FSM, counter, handshakes) in mul_iter_seq and registers, adder and shifters in one sub-module, mul_iter_dpath.
REQ-030 SHALL pass only control signals (load, add_en, shift_en) and status (b_lsb, b_zero) between control and datapath.

Verification
REQ-031 SHALL cover: a=3, b=4, ostream_rdy=1 -> ostream_msg=0x0000000C, ostream_val rising 32 cycles after acceptance (macro undefined).
REQ-032 SHALL cover: a=0xFFFFFFFD (-3), b=7 -> 0xFFFFFFEB; a=b=0xFFFFFFFF -> 0x00000001.
REQ-033 SHALL cover: ostream_rdy held 0 for 5 cycles in DONE -> ostream_val and ostream_msg stable; istream_rdy=0 throughout; IDLE on the edge after ostream_rdy rises.
REQ-034 SHALL cover: rst asserted 10 cycles into CALC -> ostream_val=0 immediately, istream_rdy=1 in the cycle after release, next request 2*5 -> 0x0000000A.
REQ-035 SHALL cover, macro defined: b=0 -> result 0 after 1 CALC cycle; a=9, b=5 -> 0x0000002D after 4 CALC cycles; b=0x80000000 -> 32 cycles.
REQ-036 SHALL cover back-to-back requests with istream_val held high -> second accepted only after the first output transfer, each result correct.
